// File: rtl/ir_pkg.sv
// Shared constants and helpers for the instruction-register prefetch queue.
package ir_pkg;

   // Default field widths of an instruction word: opcode in the upper field, operand in the lower.
   localparam int OPC_W_DEF = 8;
   localparam int OPR_W_DEF = 8;

   // Width of an occupancy counter that must represent 0..depth inclusive.
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

   // Opcode field of an instruction word; the caller casts the result to its OPC_W.
   function automatic logic [63:0] get_opc(input logic [63:0] word, input int opr_w);
      return word >> opr_w;
   endfunction

   // Operand field of an instruction word; the caller casts the result to its OPR_W.
   function automatic logic [63:0] get_opr(input logic [63:0] word, input int opr_w);
      return word & ((64'd1 << opr_w) - 64'd1);
   endfunction

endpackage

// File: rtl/ir_fifo_mem.sv
// Register-array storage for the prefetch queue: one synchronous write port, one asynchronous read port.
module ir_fifo_mem
   import ir_pkg::*;
#(
   parameter int W     = OPC_W_DEF + OPR_W_DEF,
   parameter int DEPTH = 4,
   parameter int PW    = $clog2(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_we,
   input  logic [PW-1:0] i_waddr,
   input  logic [W-1:0]  i_wdata,
   input  logic [PW-1:0] i_raddr,
   output logic [W-1:0]  o_rdata
);

   logic [DEPTH-1:0][W-1:0] mem_q;
   logic [DEPTH-1:0][W-1:0] mem_d;

   // Next-state of the array: hold every entry, overwrite the addressed one on a write.
   always_comb begin
      // NOTE: default assignment first so every path assigns mem_d and no latch is inferred.
      mem_d = mem_q;
      if (i_we) begin
         mem_d[i_waddr] = i_wdata;
      end
   end

   // Array flops; the whole array is cleared on reset so a fresh queue never exposes stale words.
   always_ff @(posedge i_clk) begin
      // NOTE: storage is reset here on purpose (small register array, cleared state is observable after reset).
      if (!i_rst_n) begin
         mem_q <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   assign o_rdata = mem_q[i_raddr];

endmodule

// File: rtl/ir_prefetch_queue.sv
// Instruction register with a DEPTH-entry prefetch FIFO between the MBR and the CU.
// Fetch may run ahead of execute; a flush (branch/interrupt) empties the queue.
module ir_prefetch_queue
   import ir_pkg::*;
#(
   parameter int OPC_W = OPC_W_DEF,
   parameter int OPR_W = OPR_W_DEF,
   parameter int DEPTH = 4
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic [OPC_W+OPR_W-1:0]    i_mbr_ir,
   input  logic                      C4,
   input  logic                      i_advance,
   input  logic                      i_flush,
   input  logic                      C14,
   input  logic                      C15,
   input  logic                      i_user_sample,
   output logic [OPC_W-1:0]          o_ir_cu,
   output logic [OPR_W-1:0]          o_ir_mbr,
   output logic [OPC_W-1:0]          o_ir_user,
   output logic                      o_valid,
   output logic                      o_full,
   output logic [cnt_w(DEPTH)-1:0]   o_count,
   output logic                      o_overflow
);

   localparam int IW = OPC_W + OPR_W;
   localparam int PW = $clog2(DEPTH);
   localparam int CW = cnt_w(DEPTH);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;

   logic          not_empty;
   logic          pop_ok;
   logic          push_ok;
   logic          mem_we;
   logic [IW-1:0] head_word;
   logic [OPC_W-1:0] head_opc;
   logic [OPR_W-1:0] head_opr;

   assign not_empty = (count_q != '0);
   // A pop frees a slot in the same cycle, so a full queue may still accept a push alongside it.
   assign pop_ok    = i_advance && not_empty;
   assign push_ok   = C4 && ((count_q != CNT_FULL) || pop_ok);
   assign mem_we    = push_ok && !i_flush;

   ir_fifo_mem #(
      .W     (IW),
      .DEPTH (DEPTH),
      .PW    (PW)
   ) u_mem (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_we    (mem_we),
      .i_waddr (wr_ptr_q),
      .i_wdata (i_mbr_ir),
      .i_raddr (rd_ptr_q),
      .o_rdata (head_word)
   );

   // Pointer, count and sticky-overflow next state; flush overrides push/pop.
   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (i_flush) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
         overflow_d = 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
         end else if (C4) begin
            overflow_d = 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
         end
         if (push_ok && !pop_ok) begin
            count_d = count_q + CW'(1);
         end else if (pop_ok && !push_ok) begin
            count_d = count_q - CW'(1);
         end
      end
   end

   // Control flops with synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
      if (!i_rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   assign head_opc = OPC_W'(get_opc(64'(head_word), OPR_W));
   assign head_opr = OPR_W'(get_opr(64'(head_word), OPR_W));

   // Gated head outputs; an empty queue always presents zero.
   always_comb begin
      o_ir_cu   = (C14 && not_empty)           ? head_opc : '0;
      o_ir_mbr  = (C15 && not_empty)           ? head_opr : '0;
      o_ir_user = (i_user_sample && not_empty) ? head_opc : '0;
   end

   assign o_valid    = not_empty;
   assign o_full     = (count_q == CNT_FULL);
   assign o_count    = count_q;
   assign o_overflow = overflow_q;

endmodule

// File: tb/tb_ir_prefetch_queue.sv
// Directed self-checking bench for ir_prefetch_queue (DEPTH=4, 8-bit opcode/operand).
module tb_ir_prefetch_queue;

   logic        clk;
   logic        rst_n;
   logic [15:0] mbr_ir;
   logic        c4, adv, flush, c14, c15, usr;
   logic [7:0]  ir_cu, ir_mbr, ir_user;
   logic        valid, full, overflow;
   logic [2:0]  count;

   int total;
   int bad;

   ir_prefetch_queue #(.OPC_W(8), .OPR_W(8), .DEPTH(4)) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_mbr_ir      (mbr_ir),
      .C4            (c4),
      .i_advance     (adv),
      .i_flush       (flush),
      .C14           (c14),
      .C15           (c15),
      .i_user_sample (usr),
      .o_ir_cu       (ir_cu),
      .o_ir_mbr      (ir_mbr),
      .o_ir_user     (ir_user),
      .o_valid       (valid),
      .o_full        (full),
      .o_count       (count),
      .o_overflow    (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock edge and settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [15:0] w);
      mbr_ir = w; c4 = 1'b1;
      tick();
      c4 = 1'b0;
   endtask

   task automatic pop();
      adv = 1'b1;
      tick();
      adv = 1'b0;
   endtask

   task automatic head(input string tag, input logic [15:0] w);
      check({tag, "_cu"},  32'(ir_cu),  32'(w[15:8]));
      check({tag, "_mbr"}, 32'(ir_mbr), 32'(w[7:0]));
   endtask

   logic [15:0] exp_a [4] = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};
   logic [15:0] exp_b [4] = '{16'hC002, 16'hC003, 16'hC004, 16'hB0B0};

   initial begin
      total = 0; bad = 0;
      rst_n = 1'b0; mbr_ir = '0; c4 = 0; adv = 0; flush = 0;
      c14 = 1'b1; c15 = 1'b1; usr = 1'b1;
      tick(); tick();
      rst_n = 1'b1;
      check("rst_count", 32'(count), 0);
      check("rst_valid", 32'(valid), 0);
      check("rst_full",  32'(full), 0);
      check("rst_ovf",   32'(overflow), 0);
      check("rst_cu",    32'(ir_cu), 0);

      // Single push, gated outputs.
      push(16'h1234);
      head("p1", 16'h1234);
      check("p1_user",  32'(ir_user), 32'h12);
      check("p1_count", 32'(count), 1);
      c14 = 1'b0; #1;
      check("p1_c14off", 32'(ir_cu), 0);
      check("p1_c14off_user", 32'(ir_user), 32'h12);
      c14 = 1'b1; #1;
      pop();
      check("p1_empty", 32'(valid), 0);

      // Fill, overflow, drain in order.
      for (int i = 0; i < 4; i++) push(exp_a[i]);
      check("fill_full",  32'(full), 1);
      check("fill_count", 32'(count), 4);
      push(16'hA005);
      check("ovf_set",   32'(overflow), 1);
      check("ovf_count", 32'(count), 4);
      for (int i = 0; i < 4; i++) begin
         head($sformatf("drainA%0d", i), exp_a[i]);
         pop();
      end
      check("drainA_valid", 32'(valid), 0);
      check("drainA_ovf_sticky", 32'(overflow), 1);

      // Full queue, simultaneous push+pop, pointer wrap.
      for (int i = 1; i <= 4; i++) push(16'hC000 + 16'(i));
      mbr_ir = 16'hB0B0; c4 = 1'b1; adv = 1'b1;
      tick();
      c4 = 1'b0; adv = 1'b0;
      check("pp_full_count", 32'(count), 4);
      for (int i = 0; i < 4; i++) begin
         head($sformatf("drainB%0d", i), exp_b[i]);
         pop();
      end
      check("drainB_count", 32'(count), 0);

      // Empty queue, simultaneous push+pop: only the push lands.
      mbr_ir = 16'h5566; c4 = 1'b1; adv = 1'b1;
      tick();
      c4 = 1'b0; adv = 1'b0;
      check("pp_empty_count", 32'(count), 1);
      head("pp_empty", 16'h5566);
      pop();
      pop();
      check("adv_empty_count", 32'(count), 0);
      check("adv_empty_valid", 32'(valid), 0);
      check("adv_empty_ovf",   32'(overflow), 1);

      // Flush with a concurrent push.
      push(16'hD001); push(16'hD002); push(16'hD003);
      check("pre_flush_count", 32'(count), 3);
      mbr_ir = 16'hEEEE; c4 = 1'b1; flush = 1'b1;
      tick();
      c4 = 1'b0; flush = 1'b0;
      check("flush_count", 32'(count), 0);
      check("flush_ovf",   32'(overflow), 0);
      check("flush_cu",    32'(ir_cu), 0);
      check("flush_valid", 32'(valid), 0);
      push(16'hF00F);
      check("post_flush_count", 32'(count), 1);
      head("post_flush", 16'hF00F);

      // Mid-stream reset.
      push(16'h1111);
      check("pre_rst_count", 32'(count), 2);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("mrst_count", 32'(count), 0);
      check("mrst_cu",    32'(ir_cu), 0);
      check("mrst_mbr",   32'(ir_mbr), 0);
      check("mrst_user",  32'(ir_user), 0);
      check("mrst_valid", 32'(valid), 0);
      check("mrst_full",  32'(full), 0);
      push(16'h7788);
      head("post_rst", 16'h7788);
      check("post_rst_count", 32'(count), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
